// File: rtl/enet_bus_arbiter.sv
// rtl/enet_bus_arbiter.sv - two-master Avalon-style arbiter onto an asynchronous external register bus
module enet_bus_arbiter #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 3,
  parameter int HOLD_CYCLES   = 1,
  parameter int ADDR_W        = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [15:0]       m0_writedata,
  output logic [15:0]       m0_readdata,
  output logic              m0_waitrequest,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [15:0]       m1_writedata,
  output logic [15:0]       m1_readdata,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] enet_addr,
  output logic [15:0]       enet_data_out,
  output logic              enet_data_oe,
  input  logic [15:0]       enet_data_in,
  output logic              enet_cs_n,
  output logic              enet_rd_n,
  output logic              enet_wr_n
);

  // A phase length of 0 is treated as 1; counter values are length-1.
  function automatic logic [3:0] load_val(input int cycles);
    if (cycles <= 1) return 4'd0;
    if (cycles >= 15) return 4'd14;
    return 4'(cycles - 1);
  endfunction

  localparam logic [3:0] SETUP_LD  = load_val(SETUP_CYCLES);
  localparam logic [3:0] STROBE_LD = load_val(STROBE_CYCLES);
  localparam logic [3:0] HOLD_LD   = load_val(HOLD_CYCLES);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              gnt;
  logic              last_gnt;
  logic              is_wr;
  logic              aborted;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [15:0]       rdata0_q, rdata1_q;

  logic req0, req1, req_any, req_g, pick, cnt_zero, ack;

  assign req0     = m0_read | m0_write;
  assign req1     = m1_read | m1_write;
  assign req_any  = req0 | req1;
  assign pick     = (req0 & req1) ? ~last_gnt : req1;
  assign req_g    = gnt ? req1 : req0;
  assign cnt_zero = (cnt == 4'd0);

  // A master that let go of its request during the access gets no ack.
  assign ack = (state == HOLD) && cnt_zero && !aborted && req_g;

  assign m0_waitrequest = req0 & ~(ack & ~gnt);
  assign m1_waitrequest = req1 & ~(ack & gnt);
  assign m0_readdata    = rdata0_q;
  assign m1_readdata    = rdata1_q;
  assign enet_addr      = addr_q;
  assign enet_data_out  = wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any)  state_nxt = SETUP;
      SETUP:   if (cnt_zero) state_nxt = STROBE;
      STROBE:  if (cnt_zero) state_nxt = HOLD;
      HOLD:    if (cnt_zero) state_nxt = TURN;
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    enet_cs_n    = 1'b1;
    enet_rd_n    = 1'b1;
    enet_wr_n    = 1'b1;
    enet_data_oe = 1'b0;
    case (state)
      SETUP, HOLD: begin
        enet_cs_n    = 1'b0;
        enet_data_oe = is_wr;
      end
      STROBE: begin
        enet_cs_n    = 1'b0;
        enet_data_oe = is_wr;
        enet_rd_n    = is_wr;
        enet_wr_n    = ~is_wr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= 4'd0;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      is_wr    <= 1'b0;
      aborted  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 16'h0000;
      rdata0_q <= 16'h0000;
      rdata1_q <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            gnt      <= pick;
            last_gnt <= pick;
            is_wr    <= pick ? m1_write : m0_write;
            addr_q   <= pick ? m1_address : m0_address;
            wdata_q  <= pick ? m1_writedata : m0_writedata;
            cnt      <= SETUP_LD;
            aborted  <= 1'b0;
          end
        end
        SETUP: cnt <= cnt_zero ? STROBE_LD : cnt - 4'd1;
        STROBE: begin
          if (cnt_zero) begin
            cnt <= HOLD_LD;
            if (!is_wr) begin
              if (gnt) rdata1_q <= enet_data_in;
              else     rdata0_q <= enet_data_in;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: cnt <= cnt_zero ? 4'd0 : cnt - 4'd1;
        default: ;
      endcase
      if ((state == SETUP || state == STROBE || state == HOLD) && !req_g)
        aborted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_enet_bus_arbiter.sv
// tb/tb_enet_bus_arbiter.sv - directed bench with a cycle-count reference model for enet_bus_arbiter
module tb_enet_bus_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        rd   [2][2];
  logic        wr   [2][2];
  logic [3:0]  ad   [2][2];
  logic [15:0] wd   [2][2];
  logic [15:0] din  [2];
  logic [15:0] rdat [2][2];
  logic        wq   [2][2];
  logic [3:0]  eaddr[2];
  logic [15:0] edo  [2];
  logic        oe[2], csn[2], rdn[2], wrn[2];

  enet_bus_arbiter u_def (
    .clk(clk), .reset_n(reset_n),
    .m0_read(rd[0][0]), .m0_write(wr[0][0]), .m0_address(ad[0][0]), .m0_writedata(wd[0][0]),
    .m0_readdata(rdat[0][0]), .m0_waitrequest(wq[0][0]),
    .m1_read(rd[0][1]), .m1_write(wr[0][1]), .m1_address(ad[0][1]), .m1_writedata(wd[0][1]),
    .m1_readdata(rdat[0][1]), .m1_waitrequest(wq[0][1]),
    .enet_addr(eaddr[0]), .enet_data_out(edo[0]), .enet_data_oe(oe[0]), .enet_data_in(din[0]),
    .enet_cs_n(csn[0]), .enet_rd_n(rdn[0]), .enet_wr_n(wrn[0])
  );

  enet_bus_arbiter #(.SETUP_CYCLES(0), .STROBE_CYCLES(15), .HOLD_CYCLES(2), .ADDR_W(4)) u_long (
    .clk(clk), .reset_n(reset_n),
    .m0_read(rd[1][0]), .m0_write(wr[1][0]), .m0_address(ad[1][0]), .m0_writedata(wd[1][0]),
    .m0_readdata(rdat[1][0]), .m0_waitrequest(wq[1][0]),
    .m1_read(rd[1][1]), .m1_write(wr[1][1]), .m1_address(ad[1][1]), .m1_writedata(wd[1][1]),
    .m1_readdata(rdat[1][1]), .m1_waitrequest(wq[1][1]),
    .enet_addr(eaddr[1]), .enet_data_out(edo[1]), .enet_data_oe(oe[1]), .enet_data_in(din[1]),
    .enet_cs_n(csn[1]), .enet_rd_n(rdn[1]), .enet_wr_n(wrn[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ack_m[$];
  int ack_c[$];

  int ps[2] = '{1, 0};
  int pt[2] = '{3, 15};
  int ph[2] = '{1, 2};

  // Model: an access occupies cycles 1..L after its grant cycle, then one turnaround cycle.
  bit          busy[2];
  int          k[2];
  int          gm[2];
  int          last[2];
  bit          mwr[2];
  bit          ab[2];
  logic [3:0]  maddr[2];
  logic [15:0] mwd[2];
  logic [15:0] rdv[2][2];

  function automatic int ef(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t: got %0h want %0h", nm, i, $time, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int s, t, l, g;
      logic ack, e_cs, e_rd, e_wr, e_oe;
      logic rq[2];
      s = ef(ps[i]);
      t = ef(pt[i]);
      l = s + t + ef(ph[i]);
      rq[0] = rd[i][0] | wr[i][0];
      rq[1] = rd[i][1] | wr[i][1];
      if (!reset_n) begin
        busy[i] = 0; k[i] = 0; gm[i] = 0; last[i] = 1; mwr[i] = 0; ab[i] = 0;
        maddr[i] = 4'h0; mwd[i] = 16'h0; rdv[i][0] = 16'h0; rdv[i][1] = 16'h0;
      end
      e_cs = 1; e_rd = 1; e_wr = 1; e_oe = 0; ack = 0;
      if (busy[i] && k[i] <= l) begin
        e_cs = 0;
        e_oe = mwr[i];
        if (k[i] > s && k[i] <= s + t) begin
          if (mwr[i]) e_wr = 0;
          else        e_rd = 0;
        end
        if (k[i] == l && !ab[i] && rq[gm[i]]) ack = 1;
      end
      chk(i, "cs_n", csn[i], e_cs);
      chk(i, "rd_n", rdn[i], e_rd);
      chk(i, "wr_n", wrn[i], e_wr);
      chk(i, "data_oe", oe[i], e_oe);
      chk(i, "addr", eaddr[i], maddr[i]);
      chk(i, "data_out", edo[i], mwd[i]);
      for (int m = 0; m < 2; m++) begin
        chk(i, m ? "m1_waitrequest" : "m0_waitrequest", wq[i][m], rq[m] & !(ack && gm[i] == m));
        chk(i, m ? "m1_readdata" : "m0_readdata", rdat[i][m], rdv[i][m]);
        if (i == 0 && reset_n && rq[m] && !wq[0][m]) begin
          ack_m.push_back(m);
          ack_c.push_back(cyc);
        end
      end
      if (reset_n) begin
        if (busy[i]) begin
          if (k[i] <= l && !rq[gm[i]]) ab[i] = 1;
          if (k[i] == s + t && !mwr[i]) rdv[i][gm[i]] = din[i];
          if (k[i] == l + 1) busy[i] = 0;
          else k[i] = k[i] + 1;
        end else if (rq[0] | rq[1]) begin
          g = (rq[0] & rq[1]) ? 1 - last[i] : (rq[1] ? 1 : 0);
          gm[i] = g; last[i] = g; mwr[i] = wr[i][g];
          maddr[i] = ad[i][g]; mwd[i] = wd[i][g];
          busy[i] = 1; k[i] = 1; ab[i] = 0;
        end
      end
    end
  end

  task automatic do_access(input int i, input int m, input bit r, input bit w, input logic [3:0] a,
                           input logic [15:0] d, input logic [15:0] di, output int lat,
                           output int nrd, output int nwr, output logic [15:0] rdv_o);
    int n;
    @(posedge clk); #2;
    rd[i][m] = r; wr[i][m] = w; ad[i][m] = a; wd[i][m] = d; din[i] = di;
    nrd = 0; nwr = 0; rdv_o = 16'h0;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!rdn[i]) nrd++;
      if (!wrn[i]) nwr++;
      if (!wq[i][m]) begin
        rdv_o = rdat[i][m];
        break;
      end
    end
    lat = n;
    @(posedge clk); #2;
    rd[i][m] = 0; wr[i][m] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, nrd, nwr;
    logic [15:0] rv;
    for (int i = 0; i < 2; i++) begin
      din[i] = 16'h0;
      for (int m = 0; m < 2; m++) begin
        rd[i][m] = 0; wr[i][m] = 0; ad[i][m] = 4'h0; wd[i][m] = 16'h0;
      end
    end
    #12;
    chk(0, "rst_cs_n", csn[0], 1);
    chk(0, "rst_rd_n", rdn[0], 1);
    chk(0, "rst_wr_n", wrn[0], 1);
    chk(0, "rst_oe", oe[0], 0);
    chk(0, "rst_addr", eaddr[0], 0);
    chk(0, "rst_rdata", rdat[0][0], 0);
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1;

    // both masters continuously: m0 first, then strict alternation every 7 cycles
    @(posedge clk); #2;
    rd[0][0] = 1; rd[0][1] = 1; ad[0][0] = 4'h1; ad[0][1] = 4'h2; din[0] = 16'hA5A5;
    ack_m.delete(); ack_c.delete();
    repeat (30) @(posedge clk);
    #2; rd[0][0] = 0; rd[0][1] = 0;
    repeat (10) @(posedge clk);
    chk(0, "rr_count", ack_m.size(), 4);
    chk(0, "rr_first", (ack_m.size() > 0) ? ack_m[0] : -1, 0);
    chk(0, "rr_second", (ack_m.size() > 1) ? ack_m[1] : -1, 1);
    chk(0, "rr_third", (ack_m.size() > 2) ? ack_m[2] : -1, 0);
    chk(0, "rr_fourth", (ack_m.size() > 3) ? ack_m[3] : -1, 1);
    chk(0, "rr_gap", (ack_m.size() > 3) ? ack_c[3] - ack_c[0] : -1, 21);

    do_access(0, 0, 1, 0, 4'h4, 16'h0, 16'h1234, lat, nrd, nwr, rv);
    chk(0, "read_latency", lat, 5);
    chk(0, "read_rd_cycles", nrd, 3);
    chk(0, "read_data", rv, 16'h1234);

    do_access(0, 1, 0, 1, 4'hA, 16'hBEEF, 16'h0, lat, nrd, nwr, rv);
    chk(0, "write_latency", lat, 5);
    chk(0, "write_wr_cycles", nwr, 3);
    chk(0, "write_rd_cycles", nrd, 0);
    @(negedge clk);
    chk(0, "turn_cs_n", csn[0], 1);
    chk(0, "turn_oe", oe[0], 0);

    do_access(0, 0, 1, 1, 4'h6, 16'h7777, 16'h0, lat, nrd, nwr, rv);
    chk(0, "rw_latency", lat, 5);
    chk(0, "rw_wr_cycles", nwr, 3);
    chk(0, "rw_rd_cycles", nrd, 0);

    // m0 drops mid-access and comes back: no ack, m1 is served next
    ack_m.delete(); ack_c.delete();
    @(posedge clk); #2; rd[0][0] = 1; ad[0][0] = 4'h1; din[0] = 16'h1111;
    @(posedge clk); #2; rd[0][1] = 1; ad[0][1] = 4'h2;
    @(posedge clk); #2; rd[0][0] = 0;
    @(posedge clk);
    @(posedge clk); #2; rd[0][0] = 1;
    @(posedge clk); @(negedge clk);
    chk(0, "abort_no_ack", wq[0][0], 1);
    repeat (16) @(posedge clk);
    #2; rd[0][0] = 0; rd[0][1] = 0;
    repeat (5) @(posedge clk);
    chk(0, "abort_acks", ack_m.size(), 2);
    chk(0, "abort_m1_first", (ack_m.size() > 0) ? ack_m[0] : -1, 1);
    chk(0, "abort_m0_second", (ack_m.size() > 1) ? ack_m[1] : -1, 0);

    // reset in the middle of a write strobe
    @(posedge clk); #2; wr[0][0] = 1; ad[0][0] = 4'h3; wd[0][0] = 16'h5A5A;
    @(posedge clk); @(posedge clk); #2;
    chk(0, "pre_rst_wr_n", wrn[0], 0);
    reset_n = 0;
    #1;
    chk(0, "arst_cs_n", csn[0], 1);
    chk(0, "arst_wr_n", wrn[0], 1);
    chk(0, "arst_oe", oe[0], 0);
    chk(0, "arst_no_ack", wq[0][0], 1);
    chk(0, "arst_rdata", rdat[0][0], 0);
    @(posedge clk); #2; wr[0][0] = 0;
    @(posedge clk); #2; reset_n = 1;
    do_access(0, 0, 1, 0, 4'h5, 16'h0, 16'hCAFE, lat, nrd, nwr, rv);
    chk(0, "post_rst_latency", lat, 5);
    chk(0, "post_rst_data", rv, 16'hCAFE);

    do_access(1, 0, 1, 0, 4'h7, 16'h0, 16'h0F0F, lat, nrd, nwr, rv);
    chk(1, "long_read_latency", lat, 18);
    chk(1, "long_rd_cycles", nrd, 15);
    chk(1, "long_read_data", rv, 16'h0F0F);
    do_access(1, 1, 0, 1, 4'h9, 16'hC3C3, 16'h0, lat, nrd, nwr, rv);
    chk(1, "long_write_latency", lat, 18);
    chk(1, "long_wr_cycles", nwr, 15);
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
